wb_regfile: RTL
===============

# wb_regfile

Write-back sink of the pipeline: consumes the `wb_*` bundle produced by the MEM/WB pipeline register and commits it into the 32×32 general-purpose register file and the HI/LO pair. It also serves the ID stage's two GPR read ports and exposes HI/LO to EX. Same-cycle write-to-read bypass is included, so ID never sees a stale value for a register being written back this cycle.

## Interface
Parameters (macros from `defines.h`, not module parameters):
- `RegBus`: 32-bit data width.
- `RegAddrBus`: 5-bit register address.
- `RegNum`: 32 registers.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high (`RstEnable` = 1).
- `wb_wd` in 5: destination GPR address.
- `wb_wreg` in 1: GPR write enable.
- `wb_wdata` in 32: GPR write data.
- `wb_whilo` in 1: HI/LO write enable.
- `wb_hi` in 32: HI write data.
- `wb_lo` in 32: LO write data.
- `re1` in 1: read-port-1 enable.
- `raddr1` in 5: read-port-1 address.
- `rdata1` out 32: read-port-1 data.
- `re2` in 1: read-port-2 enable.
- `raddr2` in 5: read-port-2 address.
- `rdata2` out 32: read-port-2 data.
- `hi_o` out 32: committed HI.
- `lo_o` out 32: committed LO.
- `hi_fwd` out 32: HI including the current-cycle write.
- `lo_fwd` out 32: LO including the current-cycle write.

## Operation
- **GPR write, at the rising edge:**
  - If `rst`=1, all 32 GPRs clear to 0 and any write on that edge is discarded.
  - Otherwise, if `wb_wreg`=1 and `wb_wd`≠0, `regs[wb_wd]` is updated with `wb_wdata`.
  - Writes to $0 are silently dropped.
- **HI/LO write, at the rising edge:**
  - If `rst`=1, HI and LO clear to 0.
  - Otherwise, if `wb_whilo`=1, HI and LO are updated with `wb_hi` and `wb_lo`. Both always update together; there are no separate HI-only or LO-only writes.
- **Read port n (n=1,2), combinational, evaluated in priority order:**
  1. `rst`=1 → 0.
  2. `raddrn`=0 → 0.
  3. `ren`=1, `wb_wreg`=1, `raddrn`=`wb_wd` → `wb_wdata` (bypass).
  4. `ren`=1 → `regs[raddrn]`.
  5. Otherwise → 0.
- **HI/LO outputs:**
  - `hi_o`/`lo_o` are the register outputs.
  - `hi_fwd`/`lo_fwd` show `wb_hi`/`wb_lo` when `wb_whilo`=1 and `rst`=0, and `hi_o`/`lo_o` otherwise.
- The two read ports are fully independent. Both may address the same register, and both may bypass in the same cycle.

## Timing
- Write latency: data presented in cycle N is in storage after edge N and visible on the non-bypassed path from cycle N+1.
- Bypass path: zero latency; data presented in cycle N is visible on `rdata*`/`*_fwd` within cycle N.
- Reset values: after a reset edge, all GPRs, HI and LO are 0.
- Outputs while `rst`=1:
  - `rdata1`=`rdata2`=0.
  - `hi_fwd`=`hi_o`, `lo_fwd`=`lo_o`.
- Reset asserted mid-stream: the pending write in that cycle is lost. The first write accepted is the one in the first cycle with `rst`=0.
- No handshake and no stalls: one write per port group per cycle, always accepted.
- Simultaneous GPR and HI/LO writes in one cycle are both committed.

## Structure
- The existing shared `defines.h` supplies `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `RstEnable`, `WriteEnable`, `ReadEnable`, and `NOPRegAddr`; no new macros.
- One sub-module, `hilo_reg`:
  - Contains the HI/LO storage and the bypass mux.
  - Instantiated once.
- The GPR array and both read muxes stay in the top module.

## Test plan
- **Reset clear:** write 0xDEADBEEF to r5; assert `rst` 1 cycle; read r5 with `re1`=1 → `rdata1`=0; `hi_o`=`lo_o`=0.
- **Write then read:** write r7=0x12345678; next cycle `raddr1`=7, `re1`=1 → 0x12345678; `re1`=0 → 0.
- **Bypass:** in the same cycle, `wb_wreg`=1, `wb_wd`=9, `wb_wdata`=0xA5A5A5A5, and `raddr1`=`raddr2`=9 with both enables high → both ports read 0xA5A5A5A5 that cycle; r9 holds 0xA5A5A5A5 afterwards.
- **$0:** write r0=0xFFFFFFFF with a same-cycle read of r0 → `rdata1`=0 that cycle and every later cycle.
- **HI/LO:** `wb_whilo`=1, hi=0x1, lo=0x2 → `hi_fwd`/`lo_fwd`=0x1/0x2 in the same cycle while `hi_o`/`lo_o` keep the old values; next cycle `hi_o`=0x1, `lo_o`=0x2.
- **Reset mid-write:** `rst`=1 together with `wb_wreg`=1 writing r3=0x55 → r3 stays 0 after `rst` deasserts.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared widths, reset/enable encodings and the read-port selection helper
// for the write-back register file.
package wb_regfile_pkg;

  localparam int REG_BUS       = 32;
  localparam int REG_ADDR_BUS  = 5;
  localparam int REG_NUM       = 32;
  localparam int REG_NUM_LOG2  = 5;

  typedef logic [REG_BUS-1:0]      word_t;
  typedef logic [REG_ADDR_BUS-1:0] addr_t;

  localparam word_t ZERO_WORD    = '0;
  localparam logic  RST_ENABLE   = 1'b1;
  localparam logic  WRITE_ENABLE = 1'b1;
  localparam logic  READ_ENABLE  = 1'b1;
  localparam addr_t NOP_REG_ADDR = '0;

  // Priority: reset, $0, same-cycle bypass, stored value, disabled port.
  function automatic word_t read_port(
    input logic  rst,
    input logic  re,
    input addr_t raddr,
    input logic  wreg,
    input addr_t wd,
    input word_t wdata,
    input word_t stored
  );
    word_t data;
    if (rst == RST_ENABLE) begin
      data = ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      data = ZERO_WORD;
    end else if (re == READ_ENABLE && wreg == WRITE_ENABLE && raddr == wd) begin
      data = wdata;
    end else if (re == READ_ENABLE) begin
      data = stored;
    end else begin
      data = ZERO_WORD;
    end
    return data;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back bundle, ID read ports and HI/LO outputs of the register file.
// No handshake: every write-back beat is accepted on the edge it is presented,
// and reads are purely combinational in the same cycle.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  addr_t wb_wd;
  logic  wb_wreg;
  word_t wb_wdata;
  logic  wb_whilo;
  word_t wb_hi;
  word_t wb_lo;

  logic  re1;
  addr_t raddr1;
  word_t rdata1;
  logic  re2;
  addr_t raddr2;
  word_t rdata2;

  word_t hi_o;
  word_t lo_o;
  word_t hi_fwd;
  word_t lo_fwd;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, hi_fwd, lo_fwd
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, hi_fwd, lo_fwd
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with a same-cycle forwarding mux for the EX stage.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  word_t hi_wdata,
  input  word_t lo_wdata,
  output word_t hi,
  output word_t lo,
  output word_t hi_fwd,
  output word_t lo_fwd
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else if (we == WRITE_ENABLE) begin
      hi <= hi_wdata;
      lo <= lo_wdata;
    end
  end

  // While in reset the forward path shows the committed pair, not the write.
  always_comb begin
    hi_fwd = hi;
    lo_fwd = lo;
    if (rst != RST_ENABLE && we == WRITE_ENABLE) begin
      hi_fwd = hi_wdata;
      lo_fwd = lo_wdata;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: 32x32 GPR file with two bypassed ID read ports, plus the
// HI/LO pair delegated to hilo_reg.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  word_t regs [REG_NUM];

  // $0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (bus.wb_wreg == WRITE_ENABLE && bus.wb_wd != NOP_REG_ADDR) begin
      regs[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wreg, bus.wb_wd,
                           bus.wb_wdata, regs[bus.raddr1]);
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wreg, bus.wb_wd,
                           bus.wb_wdata, regs[bus.raddr2]);
  end

  hilo_reg u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.wb_whilo),
    .hi_wdata (bus.wb_hi),
    .lo_wdata (bus.wb_lo),
    .hi       (bus.hi_o),
    .lo       (bus.lo_o),
    .hi_fwd   (bus.hi_fwd),
    .lo_fwd   (bus.lo_fwd)
  );

endmodule
